pll_lock_ctrl: RTL and testbench

Acquisition and lock sequencer for the pll datapath.
- Accepts a k/N/A configuration through a valid/ready handshake and drives it onto the pll inputs.
- Holds the pll in reset, then runs wide-gain acquisition, narrow-gain tracking and lock monitoring.
- Judges lock from a sampled signed phase-error stream.
- Sits between the system control interface and the pll instance.

---
 rtl/pll_ctrl_pkg.sv | 33 +++
 rtl/pll_err_qual.sv | 63 ++++++
 rtl/pll_lock_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_pll_lock_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pll_ctrl_pkg.sv
// pll_ctrl_pkg
// Shared definitions for the PLL acquisition/lock sequencer:
//   - state_t     : FSM state encoding (also exported on the debug state port)
//   - CFG_W       : width of the signed k/N/A config words and of phase_err
//   - abs_sat()   : saturating magnitude of a signed config-width value
package pll_ctrl_pkg;

   localparam int CFG_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RST    = 3'd1,
      ST_ACQ    = 3'd2,
      ST_TRACK  = 3'd3,
      ST_LOCKED = 3'd4,
      ST_FAULT  = 3'd5
   } state_t;

   // Magnitude of a two's complement value; the most negative code has no
   // positive counterpart, so it is clamped to the largest positive code.
   function automatic logic [CFG_W-1:0] abs_sat(input logic [CFG_W-1:0] v);
      logic [CFG_W-1:0] r;
      if (v == {1'b1, {(CFG_W-1){1'b0}}}) begin
         r = {1'b0, {(CFG_W-1){1'b1}}};
      end else if (v[CFG_W-1]) begin
         r = (~v) + {{(CFG_W-1){1'b0}}, 1'b1};
      end else begin
         r = v;
      end
      return r;
   endfunction

endpackage

// File: rtl/pll_err_qual.sv
// pll_err_qual
// Classifies each strobed phase-error sample as good (|err| <= LOCK_THRESH)
// or bad and keeps consecutive good/bad run lengths.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   clr         : zero both run counters (FSM state entry)
//   err_valid   : sample strobe, already gated by the FSM
//   phase_err   : signed phase error
//   good_cnt    : consecutive good samples (saturates at all-ones)
//   bad_cnt     : consecutive bad samples (saturates at all-ones)
module pll_err_qual
   import pll_ctrl_pkg::*;
#(
   parameter int CNT_W       = 12,
   parameter int LOCK_THRESH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             err_valid,
   input  logic [CFG_W-1:0] phase_err,
   output logic [CNT_W-1:0] good_cnt,
   output logic [CNT_W-1:0] bad_cnt
);

   localparam logic [CFG_W-1:0] THRESH_C = CFG_W'(LOCK_THRESH);
   localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CFG_W-1:0] mag_s;
   logic             good_s;
   logic [CNT_W-1:0] good_cnt_r;
   logic [CNT_W-1:0] bad_cnt_r;

   // Sample magnitude and threshold classification
   always_comb begin
      mag_s  = abs_sat(phase_err);
      good_s = (mag_s <= THRESH_C);
   end

   // Consecutive run counters: a sample of one kind breaks the other run
   always_ff @(posedge clk) begin
      if (reset) begin
         good_cnt_r <= {CNT_W{1'b0}};
         bad_cnt_r  <= {CNT_W{1'b0}};
      end else if (clr) begin
         good_cnt_r <= {CNT_W{1'b0}};
         bad_cnt_r  <= {CNT_W{1'b0}};
      end else if (err_valid) begin
         if (good_s) begin
            good_cnt_r <= (good_cnt_r == CNT_MAX_C) ? good_cnt_r : good_cnt_r + CNT_ONE_C;
            bad_cnt_r  <= {CNT_W{1'b0}};
         end else begin
            good_cnt_r <= {CNT_W{1'b0}};
            bad_cnt_r  <= (bad_cnt_r == CNT_MAX_C) ? bad_cnt_r : bad_cnt_r + CNT_ONE_C;
         end
      end
   end

   assign good_cnt = good_cnt_r;
   assign bad_cnt  = bad_cnt_r;

endmodule

// File: rtl/pll_lock_ctrl.sv
// pll_lock_ctrl
// Acquisition and lock sequencer for the PLL datapath. Latches k/N/A config
// through a valid/ready handshake, holds the PLL in reset, then steps through
// wide-gain acquisition, narrow-gain tracking and lock monitoring, judging
// lock from the strobed phase-error stream.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   cfg_valid/cfg_ready   : config handshake (ready only in IDLE and FAULT)
//   cfg_k, cfg_n, cfg_a   : signed config words
//   start, stop           : single-cycle control pulses
//   err_valid, phase_err  : phase-error sample stream
//   pll_reset             : PLL reset (high in IDLE, RST, FAULT)
//   pll_k, pll_n, pll_a   : latched config driven to the PLL
//   gain_sel              : 1 = wide acquisition gain (ACQ only)
//   locked, fault         : status flags
//   state                 : current state code
// All outputs come straight from flops; there is no input-to-output path.
module pll_lock_ctrl
   import pll_ctrl_pkg::*;
#(
   parameter int LOCK_THRESH = 8,
   parameter int LOCK_CNT    = 16,
   parameter int UNLOCK_CNT  = 4,
   parameter int ACQ_TIMEOUT = 1024,
   parameter int RST_CYCLES  = 4,
   parameter int CNT_W       = 12
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CFG_W-1:0] cfg_k,
   input  logic [CFG_W-1:0] cfg_n,
   input  logic [CFG_W-1:0] cfg_a,
   input  logic             start,
   input  logic             stop,
   input  logic             err_valid,
   input  logic [CFG_W-1:0] phase_err,
   output logic             pll_reset,
   output logic [CFG_W-1:0] pll_k,
   output logic [CFG_W-1:0] pll_n,
   output logic [CFG_W-1:0] pll_a,
   output logic             gain_sel,
   output logic             locked,
   output logic             fault,
   output logic [2:0]       state
);

   // Counters are compared on the cycle before a transition, so the timers
   // use "last cycle" constants: RST lasts exactly RST_CYCLES cycles and the
   // ACQ/TRACK budget expires exactly ACQ_TIMEOUT cycles after ACQ entry.
   localparam logic [CNT_W-1:0] HALF_C      = CNT_W'(LOCK_CNT / 2);
   localparam logic [CNT_W-1:0] LOCK_C      = CNT_W'(LOCK_CNT);
   localparam logic [CNT_W-1:0] UNLOCK_C    = CNT_W'(UNLOCK_CNT);
   localparam logic [CNT_W-1:0] RST_LAST_C  = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LAST_C  = CNT_W'(ACQ_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE_C   = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_r;
   state_t           state_nxt_s;
   logic [CNT_W-1:0] rst_cnt_r;
   logic [CNT_W-1:0] tmo_cnt_r;
   logic [CFG_W-1:0] pll_k_r;
   logic [CFG_W-1:0] pll_n_r;
   logic [CFG_W-1:0] pll_a_r;
   logic             cfg_ready_r;
   logic             pll_reset_r;
   logic             gain_sel_r;
   logic             locked_r;
   logic             fault_r;
   logic             hs_s;
   logic [CFG_W-1:0] eff_n_s;
   logic             clr_s;
   logic             err_en_s;
   logic [CNT_W-1:0] good_cnt_s;
   logic [CNT_W-1:0] bad_cnt_s;
   logic             pll_reset_nxt_s;
   logic             cfg_ready_nxt_s;
   logic             gain_sel_nxt_s;
   logic             locked_nxt_s;
   logic             fault_nxt_s;

   // Handshake, effective N for the start check, sample gating
   always_comb begin
      hs_s     = cfg_valid & cfg_ready_r;
      eff_n_s  = hs_s ? cfg_n : pll_n_r;
      err_en_s = err_valid & ((state_r == ST_ACQ) || (state_r == ST_TRACK) ||
                              (state_r == ST_LOCKED));
   end

   pll_err_qual #(
      .CNT_W       (CNT_W),
      .LOCK_THRESH (LOCK_THRESH)
   ) u_qual (
      .clk       (clk),
      .reset     (reset),
      .clr       (clr_s),
      .err_valid (err_en_s),
      .phase_err (phase_err),
      .good_cnt  (good_cnt_s),
      .bad_cnt   (bad_cnt_s)
   );

   // Next-state logic; stop wins, then timers, then sample counts
   always_comb begin
      state_nxt_s = state_r;
      clr_s       = 1'b0;
      if (stop) begin
         state_nxt_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE, ST_FAULT: begin
               if (start) begin
                  state_nxt_s = (eff_n_s == {CFG_W{1'b0}}) ? ST_FAULT : ST_RST;
               end else begin
                  state_nxt_s = state_r;
               end
            end
            ST_RST: begin
               if (rst_cnt_r == RST_LAST_C) begin
                  state_nxt_s = ST_ACQ;
                  clr_s       = 1'b1;
               end else begin
                  state_nxt_s = ST_RST;
               end
            end
            ST_ACQ: begin
               if (tmo_cnt_r == TMO_LAST_C) begin
                  state_nxt_s = ST_FAULT;
               end else if (good_cnt_s >= HALF_C) begin
                  state_nxt_s = ST_TRACK;
                  clr_s       = 1'b1;
               end else begin
                  state_nxt_s = ST_ACQ;
               end
            end
            ST_TRACK: begin
               if (tmo_cnt_r == TMO_LAST_C) begin
                  state_nxt_s = ST_FAULT;
               end else if (bad_cnt_s >= UNLOCK_C) begin
                  state_nxt_s = ST_ACQ;
                  clr_s       = 1'b1;
               end else if (good_cnt_s >= LOCK_C) begin
                  state_nxt_s = ST_LOCKED;
               end else begin
                  state_nxt_s = ST_TRACK;
               end
            end
            ST_LOCKED: begin
               if (bad_cnt_s >= UNLOCK_C) begin
                  state_nxt_s = ST_ACQ;
                  clr_s       = 1'b1;
               end else begin
                  state_nxt_s = ST_LOCKED;
               end
            end
            default: begin
               state_nxt_s = ST_IDLE;
            end
         endcase
      end
   end

   // Output decode of the next state, registered alongside the state
   always_comb begin
      pll_reset_nxt_s = 1'b1;
      cfg_ready_nxt_s = 1'b0;
      gain_sel_nxt_s  = 1'b0;
      locked_nxt_s    = 1'b0;
      fault_nxt_s     = 1'b0;
      case (state_nxt_s)
         ST_IDLE:   cfg_ready_nxt_s = 1'b1;
         ST_RST:    pll_reset_nxt_s = 1'b1;
         ST_ACQ: begin
            pll_reset_nxt_s = 1'b0;
            gain_sel_nxt_s  = 1'b1;
         end
         ST_TRACK:  pll_reset_nxt_s = 1'b0;
         ST_LOCKED: begin
            pll_reset_nxt_s = 1'b0;
            locked_nxt_s    = 1'b1;
         end
         ST_FAULT: begin
            cfg_ready_nxt_s = 1'b1;
            fault_nxt_s     = 1'b1;
         end
         default:   pll_reset_nxt_s = 1'b1;
      endcase
   end

   // State, timers, config and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         rst_cnt_r   <= {CNT_W{1'b0}};
         tmo_cnt_r   <= {CNT_W{1'b0}};
         pll_k_r     <= {CFG_W{1'b0}};
         pll_n_r     <= {CFG_W{1'b0}};
         pll_a_r     <= {CFG_W{1'b0}};
         cfg_ready_r <= 1'b1;
         pll_reset_r <= 1'b1;
         gain_sel_r  <= 1'b0;
         locked_r    <= 1'b0;
         fault_r     <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         cfg_ready_r <= cfg_ready_nxt_s;
         pll_reset_r <= pll_reset_nxt_s;
         gain_sel_r  <= gain_sel_nxt_s;
         locked_r    <= locked_nxt_s;
         fault_r     <= fault_nxt_s;
         // RST dwell counter restarts from zero on every RST entry
         rst_cnt_r   <= (state_r == ST_RST) ? rst_cnt_r + CNT_ONE_C : {CNT_W{1'b0}};
         // Timeout spans ACQ and TRACK together, restarting on each ACQ entry
         if ((state_nxt_s == ST_ACQ) && (state_r != ST_ACQ)) begin
            tmo_cnt_r <= {CNT_W{1'b0}};
         end else if ((state_r == ST_ACQ) || (state_r == ST_TRACK)) begin
            tmo_cnt_r <= tmo_cnt_r + CNT_ONE_C;
         end
         if (hs_s) begin
            pll_k_r <= cfg_k;
            pll_n_r <= cfg_n;
            pll_a_r <= cfg_a;
         end
      end
   end

   assign state     = state_r;
   assign cfg_ready = cfg_ready_r;
   assign pll_reset = pll_reset_r;
   assign gain_sel  = gain_sel_r;
   assign locked    = locked_r;
   assign fault     = fault_r;
   assign pll_k     = pll_k_r;
   assign pll_n     = pll_n_r;
   assign pll_a     = pll_a_r;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// tb_pll_lock_ctrl
// Directed bench for pll_lock_ctrl: a vector table for reset/config/RST
// entry, then hand-written sequences for lock, unlock, timeout, threshold
// edges, stop and the N==0 fault path. Outputs are checked 1 time unit
// after each rising edge.
module tb_pll_lock_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [7:0] cfg_k, cfg_n, cfg_a;
   logic       start, stop, err_valid;
   logic [7:0] phase_err;
   logic       pll_reset;
   logic [7:0] pll_k, pll_n, pll_a;
   logic       gain_sel, locked, fault;
   logic [2:0] state;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic       cv;
      logic [7:0] k, n, a;
      logic       st, sp, ev;
      logic [7:0] pe;
      logic [2:0] es;
      logic       er, ecr, eg;
      logic [7:0] en;
   } vec_t;

   vec_t tbl[7];

   pll_lock_ctrl dut (
      .clk(clk), .reset(reset),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_k(cfg_k), .cfg_n(cfg_n), .cfg_a(cfg_a),
      .start(start), .stop(stop),
      .err_valid(err_valid), .phase_err(phase_err),
      .pll_reset(pll_reset), .pll_k(pll_k), .pll_n(pll_n), .pll_a(pll_a),
      .gain_sel(gain_sel), .locked(locked), .fault(fault), .state(state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      cfg_valid = 1'b0; cfg_k = 8'd0; cfg_n = 8'd0; cfg_a = 8'd0;
      start = 1'b0; stop = 1'b0; err_valid = 1'b0; phase_err = 8'd0;
   endtask

   task automatic sample(input logic ev, input logic [7:0] pe);
      err_valid = ev;
      phase_err = pe;
   endtask

   initial begin
      logic [7:0] useq[8];
      int         early;

      //          cv    k      n      a      st    sp    ev    pe     es    er    ecr   eg    en
      tbl[0] = '{1'b0, 8'd0,  8'd0,  8'd0,  1'b0, 1'b0, 1'b0, 8'd0,  3'd0, 1'b1, 1'b1, 1'b0, 8'd0};
      tbl[1] = '{1'b0, 8'd0,  8'd0,  8'd0,  1'b0, 1'b0, 1'b1, 8'd0,  3'd0, 1'b1, 1'b1, 1'b0, 8'd0};
      tbl[2] = '{1'b1, 8'd3,  8'd16, 8'd64, 1'b1, 1'b0, 1'b0, 8'd0,  3'd1, 1'b1, 1'b0, 1'b0, 8'd16};
      tbl[3] = '{1'b1, 8'd7,  8'd99, 8'd1,  1'b0, 1'b0, 1'b0, 8'd0,  3'd1, 1'b1, 1'b0, 1'b0, 8'd16};
      tbl[4] = '{1'b0, 8'd0,  8'd0,  8'd0,  1'b0, 1'b0, 1'b1, 8'd0,  3'd1, 1'b1, 1'b0, 1'b0, 8'd16};
      tbl[5] = '{1'b0, 8'd0,  8'd0,  8'd0,  1'b0, 1'b0, 1'b0, 8'd0,  3'd1, 1'b1, 1'b0, 1'b0, 8'd16};
      tbl[6] = '{1'b0, 8'd0,  8'd0,  8'd0,  1'b0, 1'b0, 1'b0, 8'd0,  3'd2, 1'b0, 1'b0, 1'b1, 8'd16};

      quiet();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      chk("rst_state", state, 3'd0);
      chk("rst_pll_reset", pll_reset, 1'b1);
      chk("rst_cfg_ready", cfg_ready, 1'b1);
      chk("rst_locked", locked, 1'b0);
      chk("rst_fault", fault, 1'b0);
      chk("rst_gain", gain_sel, 1'b0);
      chk("rst_pll_kna", {pll_k, pll_n, pll_a}, 24'd0);

      // Table: idle, ignored samples, config+start, RST dwell, ACQ entry
      for (int i = 0; i < 7; i++) begin
         cfg_valid = tbl[i].cv; cfg_k = tbl[i].k; cfg_n = tbl[i].n; cfg_a = tbl[i].a;
         start = tbl[i].st; stop = tbl[i].sp;
         err_valid = tbl[i].ev; phase_err = tbl[i].pe;
         tick();
         chk($sformatf("v%0d_state", i), state, tbl[i].es);
         chk($sformatf("v%0d_pll_reset", i), pll_reset, tbl[i].er);
         chk($sformatf("v%0d_cfg_ready", i), cfg_ready, tbl[i].ecr);
         chk($sformatf("v%0d_gain", i), gain_sel, tbl[i].eg);
         chk($sformatf("v%0d_pll_n", i), pll_n, tbl[i].en);
      end
      quiet();
      chk("cfg_pll_k", pll_k, 8'd3);
      chk("cfg_pll_a", pll_a, 8'd64);

      // Lock: good count 8 visible after sample 8 -> TRACK on sample 9;
      // 16 more good in TRACK -> LOCKED on the following edge
      for (int i = 1; i <= 26; i++) begin
         sample(1'b1, 8'd2);
         tick();
         if (i == 8)  chk("lock_acq8", state, 3'd2);
         if (i == 9)  chk("lock_track9", state, 3'd3);
         if (i == 9)  chk("lock_track_gain", gain_sel, 1'b0);
         if (i == 25) chk("lock_track25", state, 3'd3);
         if (i == 26) chk("lock_locked", state, 3'd4);
         if (i == 26) chk("lock_locked_flag", locked, 1'b1);
      end

      // Unlock: 3 bad, 1 good, 4 bad -> still LOCKED, then ACQ next edge
      useq = '{8'h80, 8'h80, 8'h80, 8'd2, 8'h80, 8'h80, 8'h80, 8'h80};
      for (int i = 0; i < 8; i++) begin
         sample(1'b1, useq[i]);
         tick();
         chk($sformatf("unlock_hold%0d", i), state, 3'd4);
      end
      sample(1'b0, 8'd0);
      tick();
      chk("unlock_acq", state, 3'd2);
      chk("unlock_locked0", locked, 1'b0);
      chk("unlock_gain1", gain_sel, 1'b1);

      // Timeout: FAULT exactly 1024 edges after ACQ entry
      early = 0;
      sample(1'b1, 8'd40);
      for (int i = 1; i <= 1024; i++) begin
         tick();
         if (i < 1024 && state != 3'd2) early++;
      end
      chk("tmo_no_early", early, 0);
      chk("tmo_fault_state", state, 3'd5);
      chk("tmo_fault_flag", fault, 1'b1);
      chk("tmo_pll_reset", pll_reset, 1'b1);
      chk("tmo_cfg_ready", cfg_ready, 1'b1);
      sample(1'b0, 8'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("fault_start_rst", state, 3'd1);
      chk("fault_start_fault0", fault, 1'b0);
      tick(); tick(); tick();
      chk("rst2_hold", state, 3'd1);
      tick();
      chk("rst2_acq", state, 3'd2);

      // Threshold edges: +8 and -8 are good, +9 is bad
      for (int i = 1; i <= 9; i++) begin
         sample(1'b1, (i % 2 == 1) ? 8'd8 : 8'hF8);
         tick();
         if (i == 8) chk("thr_acq8", state, 3'd2);
         if (i == 9) chk("thr_track", state, 3'd3);
      end
      for (int i = 1; i <= 4; i++) begin
         sample(1'b1, 8'd9);
         tick();
      end
      chk("thr_bad4_track", state, 3'd3);
      sample(1'b0, 8'd0);
      tick();
      chk("thr_back_acq", state, 3'd2);

      // Re-acquire TRACK, then stop mid-TRACK
      for (int i = 1; i <= 10; i++) begin
         sample(1'b1, 8'd0);
         tick();
      end
      chk("stop_pre_track", state, 3'd3);
      sample(1'b0, 8'd0);
      stop = 1'b1;
      tick();
      chk("stop_idle", state, 3'd0);
      chk("stop_gain0", gain_sel, 1'b0);
      chk("stop_pll_reset", pll_reset, 1'b1);
      chk("stop_cfg_ready", cfg_ready, 1'b1);
      tick();
      chk("stop_in_idle", state, 3'd0);
      stop = 1'b0;

      // N==0 held in pll_n, then start -> FAULT
      cfg_valid = 1'b1; cfg_k = 8'd1; cfg_n = 8'd0; cfg_a = 8'd1;
      tick();
      cfg_valid = 1'b0;
      chk("n0_latched", pll_n, 8'd0);
      chk("n0_idle", state, 3'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("n0_fault", state, 3'd5);
      chk("n0_fault_flag", fault, 1'b1);
      start = 1'b1;
      tick();
      chk("n0_fault_stays", state, 3'd5);

      // FAULT with handshake N=5 and start -> RST using the new N
      cfg_valid = 1'b1; cfg_n = 8'd5;
      tick();
      quiet();
      chk("fault_hs_rst", state, 3'd1);
      chk("fault_hs_pll_n", pll_n, 8'd5);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("rst_stop_idle", state, 3'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
